jtframe_rst_seq: RTL and testbench

//  Consumer side of the clock/reset generator: orders reset release for one clock domain.

---
 rtl/jtframe_rst_seq.sv | 143 ++++++++++++++
 tb/tb_jtframe_rst_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rst_seq.sv
// Reset release sequencer for one clock domain: PLL lock qualification,
// SDRAM reset release, SDRAM ready wait, then game reset release.
//
// state  | meaning
// WLOCK  | waiting for lk to stay high LOCK_CNT cycles, all resets held
// WSDRAM | SDRAM reset released, waiting for sdram_rdy or timeout
// WDLY   | SDRAM up, game reset held for GAME_DLY more cycles
// RUN    | all resets released
// GRST   | game-only reset pulse, SDRAM left running
module jtframe_rst_seq #(
    parameter int CW       = 16,
    parameter int LOCK_CNT = 1000,
    parameter int SDRAM_TO = 40000,
    parameter int GAME_DLY = 64,
    parameter int GAME_MIN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sdram_rdy,
    input  logic       game_rst,
    output logic       rst_sdram,
    output logic       rst_game,
    output logic [2:0] seq_st,
    output logic       sdram_to,
    output logic       lock_lost
);

    localparam longint CNT_LIM = longint'(1) << CW;

    if (LOCK_CNT < 1 || longint'(LOCK_CNT) >= CNT_LIM ||
        SDRAM_TO < 1 || longint'(SDRAM_TO) >= CNT_LIM ||
        GAME_DLY < 1 || longint'(GAME_DLY) >= CNT_LIM ||
        GAME_MIN < 1 || longint'(GAME_MIN) >= CNT_LIM) begin : g_param_err
        $error("jtframe_rst_seq: delay parameters must be in 1..2^CW-1");
    end

    localparam logic [CW-1:0] LOCK_TC  = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] SDRAM_TC = CW'(SDRAM_TO - 1);
    localparam logic [CW-1:0] DLY_TC   = CW'(GAME_DLY - 1);
    localparam logic [CW-1:0] MIN_TC   = CW'(GAME_MIN - 1);

    typedef enum logic [2:0] {
        WLOCK  = 3'd0,
        WSDRAM = 3'd1,
        WDLY   = 3'd2,
        RUN    = 3'd3,
        GRST   = 3'd4
    } state_t;

    state_t        st, st_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          to_nx, lost_nx;
    logic          lk_s1, lk;
    logic          lock_drop;

    // Plain two-flop synchroniser, deliberately not reset
    always_ff @(posedge clk) begin
        lk_s1 <= pll_locked;
        lk    <= lk_s1;
    end

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);
    assign lock_drop = !lk && (st inside {WSDRAM, WDLY, RUN, GRST});
    assign seq_st    = st;

    always_comb begin
        st_nx   = st;
        cnt_nx  = cnt_inc;
        to_nx   = sdram_to;
        lost_nx = lock_lost;
        if (lock_drop) begin
            st_nx   = WLOCK;
            cnt_nx  = '0;
            lost_nx = 1'b1;
        end else begin
            case (st)
                WLOCK: begin
                    if (!lk) begin
                        cnt_nx = '0;
                    end else if (cnt == LOCK_TC) begin
                        st_nx  = WSDRAM;
                        cnt_nx = '0;
                    end
                end
                WSDRAM: begin
                    // a ready arriving on the timeout cycle is not a timeout
                    if (sdram_rdy) begin
                        st_nx  = WDLY;
                        cnt_nx = '0;
                    end else if (cnt == SDRAM_TC) begin
                        st_nx  = WDLY;
                        cnt_nx = '0;
                        to_nx  = 1'b1;
                    end
                end
                WDLY: begin
                    if (cnt == DLY_TC) begin
                        st_nx  = RUN;
                        cnt_nx = '0;
                    end
                end
                RUN: begin
                    cnt_nx = '0;
                    if (game_rst) st_nx = GRST;
                end
                GRST: begin
                    if (cnt >= MIN_TC) begin
                        cnt_nx = MIN_TC;
                        if (!game_rst) begin
                            st_nx  = RUN;
                            cnt_nx = '0;
                        end
                    end
                end
                default: begin
                    st_nx  = WLOCK;
                    cnt_nx = '0;
                end
            endcase
        end
    end

    // Reset outputs decode the next state so they leave the flops glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= WLOCK;
            cnt       <= '0;
            sdram_to  <= 1'b0;
            lock_lost <= 1'b0;
            rst_sdram <= 1'b1;
            rst_game  <= 1'b1;
        end else begin
            st        <= st_nx;
            cnt       <= cnt_nx;
            sdram_to  <= to_nx;
            lock_lost <= lost_nx;
            rst_sdram <= (st_nx == WLOCK);
            rst_game  <= (st_nx != RUN);
        end
    end

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Self-checking bench for jtframe_rst_seq: directed scenarios with randomized
// timing plus a random soak, all compared against a phase/elapsed-time model.
module tb_jtframe_rst_seq;

    localparam int LOCK_CNT = 1000;
    localparam int SDRAM_TO = 40000;
    localparam int GAME_DLY = 64;
    localparam int GAME_MIN = 16;

    localparam int P_WLOCK = 0, P_WSDRAM = 1, P_WDLY = 2, P_RUN = 3, P_GRST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sdram_rdy = 1'b0;
    logic       game_rst = 1'b0;
    logic       rst_sdram, rst_game, sdram_to, lock_lost;
    logic [2:0] seq_st;

    always #5 clk = ~clk;

    jtframe_rst_seq #(
        .CW(16), .LOCK_CNT(LOCK_CNT), .SDRAM_TO(SDRAM_TO),
        .GAME_DLY(GAME_DLY), .GAME_MIN(GAME_MIN)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .sdram_rdy(sdram_rdy),
        .game_rst(game_rst), .rst_sdram(rst_sdram), .rst_game(rst_game),
        .seq_st(seq_st), .sdram_to(sdram_to), .lock_lost(lock_lost)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference: current phase, cycles elapsed in it, sticky flags, lock pipe
    int m_ph = P_WLOCK, m_n = 0;
    bit m_to = 0, m_lost = 0, m_p1 = 0, m_p2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_edge();
        bit lk;
        lk   = m_p2;
        m_p2 = m_p1;
        m_p1 = pll_locked;
        if (rst) begin
            m_ph = P_WLOCK; m_n = 0; m_to = 0; m_lost = 0;
            return;
        end
        if (m_ph != P_WLOCK && !lk) begin
            m_ph = P_WLOCK; m_n = 0; m_lost = 1;
            return;
        end
        case (m_ph)
            P_WLOCK: begin
                m_n = lk ? m_n + 1 : 0;
                if (m_n == LOCK_CNT) begin m_ph = P_WSDRAM; m_n = 1; end
            end
            P_WSDRAM: begin
                if (sdram_rdy) begin m_ph = P_WDLY; m_n = 1; end
                else if (m_n == SDRAM_TO) begin m_ph = P_WDLY; m_n = 1; m_to = 1; end
                else m_n++;
            end
            P_WDLY: begin
                if (m_n == GAME_DLY) begin m_ph = P_RUN; m_n = 0; end
                else m_n++;
            end
            P_RUN: begin
                if (game_rst) begin m_ph = P_GRST; m_n = 1; end
            end
            default: begin
                if (m_n >= GAME_MIN && !game_rst) begin m_ph = P_RUN; m_n = 0; end
                else m_n++;
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        check("seq_st", 32'(seq_st), 32'(m_ph));
        check("rst_sdram", 32'(rst_sdram), 32'(m_ph == P_WLOCK));
        check("rst_game", 32'(rst_game), 32'(m_ph != P_RUN));
        check("sdram_to", 32'(sdram_to), 32'(m_to));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
        check("order", 32'(rst_sdram & ~rst_game), 32'd0);
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic game_pulse(input int len);
        int hi = 0;
        game_rst = 1'b1;
        repeat (len) begin step(); hi += int'(rst_game); end
        game_rst = 1'b0;
        for (int k = 0; k < 80 && rst_game; k++) begin step(); hi += int'(rst_game); end
        check("grst_len", 32'(hi), 32'(len > GAME_MIN ? len : GAME_MIN));
    endtask

    initial begin
        int t, g, len;

        // power-up
        steps(3);
        check("rst_vals", {rst_sdram, rst_game, seq_st, sdram_to, lock_lost}, 7'b11_000_00);
        rst = 1'b0;
        pll_locked = 1'b1;
        t = cyc;
        for (int k = 0; k < 1100 && rst_sdram; k++) step();
        check("t1_sdram_rel", 32'(cyc - t), 32'd1002);
        steps(50);
        sdram_rdy = 1'b1;
        t = cyc;
        for (int k = 0; k < 200 && rst_game; k++) step();
        check("t1_game_rel", 32'(cyc - t), 32'd65);
        check("t1_run", 32'(seq_st), 32'd3);

        // game-only reset: short, long and random pulses
        steps(5);
        game_pulse(3);
        steps(4);
        game_pulse(40);
        steps(3);
        game_pulse($urandom_range(1, 30));
        check("t5_run", 32'(seq_st), 32'd3);

        // lock loss in RUN, then relock
        steps($urandom_range(1, 20));
        pll_locked = 1'b0;
        t = cyc;
        for (int k = 0; k < 10 && !(rst_sdram && rst_game); k++) step();
        check("t3_loss_lat", 32'(cyc - t), 32'd3);
        check("t3_lost", 32'(lock_lost), 32'd1);
        steps($urandom_range(1, 20));
        pll_locked = 1'b1;
        for (int k = 0; k < 1200 && seq_st != 3'd3; k++) step();
        check("t3_rerun", 32'(seq_st), 32'd3);

        // lock loss coincident with game_rst
        steps(5);
        pll_locked = 1'b0;
        steps(2);
        game_rst = 1'b1;
        step();
        check("t6_state", 32'(seq_st), 32'd0);
        check("t6_resets", {rst_sdram, rst_game}, 2'b11);
        game_rst = 1'b0;
        steps(3);

        // lock glitch while qualifying
        rst = 1'b1;
        step();
        check("t2_rst", {rst_sdram, rst_game, seq_st, sdram_to, lock_lost}, 7'b11_000_00);
        rst = 1'b0;
        sdram_rdy = 1'b0;
        pll_locked = 1'b1;
        g = $urandom_range(100, 900);
        steps(g);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        t = cyc;
        for (int k = 0; k < 1200 && rst_sdram; k++) step();
        check("t2_sdram_rel", 32'(cyc - t), 32'd1002);
        check("t2_lost", 32'(lock_lost), 32'd0);

        // SDRAM ready timeout
        t = cyc;
        for (int k = 0; k < SDRAM_TO + 100 && !sdram_to; k++) step();
        check("t4_to_time", 32'(cyc - t), 32'(SDRAM_TO));
        check("t4_state", 32'(seq_st), 32'd2);
        t = cyc;
        for (int k = 0; k < 200 && rst_game; k++) step();
        check("t4_game_rel", 32'(cyc - t), 32'(GAME_DLY));

        // reset asserted part-way through WDLY
        rst = 1'b1;
        step();
        rst = 1'b0;
        sdram_rdy = 1'b1;
        for (int k = 0; k < 1200 && seq_st != 3'd2; k++) step();
        steps($urandom_range(2, 40));
        check("wdly_pre", 32'(seq_st), 32'd2);
        rst = 1'b1;
        step();
        check("wdly_rst", {rst_sdram, rst_game, seq_st, sdram_to, lock_lost}, 7'b11_000_00);
        rst = 1'b0;

        // random soak
        for (int k = 0; k < 6000; k++) begin
            if (pll_locked) pll_locked = ($urandom_range(0, 1999) != 0);
            else            pll_locked = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) sdram_rdy = ~sdram_rdy;
            if ($urandom_range(0, 29) == 0) game_rst = ~game_rst;
            rst = ($urandom_range(0, 4999) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
